// File: rtl/seq_csa_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: partial-product rows are folded into carry-save
// sum/carry registers ROWS_PER_CYCLE at a time, then a ripple merge forms the product.
module seq_csa_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1,
  parameter int SIGNED_EN      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ROWS_ALL = CW'(WIDTH);
  localparam logic [CW-1:0] ROW_STEP = CW'(ROWS_PER_CYCLE);
  // Baugh-Wooley correction constants: +2^WIDTH and +2^(2*WIDTH-1)
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef enum logic [1:0] {IDLE, BUSY, MERGE, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_r, b_r;
  logic              signed_r;
  logic [PW-1:0]     sum_r, carry_r;
  logic [PW-1:0]     sum_nxt, carry_nxt;
  logic [CW-1:0]     row_cnt;
  logic [CW-1:0]     ridx;
  logic [PW-1:0]     pp_v, csh_v;
  logic [1:0]        acc_fa;
  logic [PW-1:0]     csh_m, merge_v;
  logic [1:0]        mrg_fa;
  logic              rc;

  // Returns {carry, sum} of one full-adder cell
  function automatic logic [1:0] fa(input logic s_in, input logic c_in, input logic side_in);
    fa = {(s_in & c_in) | (s_in & side_in) | (c_in & side_in), s_in ^ c_in ^ side_in};
  endfunction

  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] av,
                                           input logic [WIDTH-1:0] bv,
                                           input logic [CW-1:0]    idx,
                                           input logic             sgn);
    logic [WIDTH-1:0] bits;
    logic             bbit;
    logic             last_row;
    bbit     = |(bv & (WIDTH'(1) << idx));
    last_row = (idx == CW'(WIDTH - 1));
    for (int k = 0; k < WIDTH; k++)
      bits[k] = (av[k] & bbit) ^ (sgn & ((k == WIDTH - 1) != last_row));
    pp_row = {{WIDTH{1'b0}}, bits} << idx;
    // Row 0 never reaches bit WIDTH, so the constants ride along with it
    if (sgn && idx == '0)
      pp_row = pp_row | BW_CONST;
  endfunction

  always_comb begin
    sum_nxt   = sum_r;
    carry_nxt = carry_r;
    ridx      = '0;
    pp_v      = '0;
    csh_v     = '0;
    acc_fa    = '0;
    for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
      ridx  = row_cnt + CW'(r);
      pp_v  = pp_row(a_r, b_r, ridx, signed_r);
      csh_v = carry_nxt << 1;
      for (int k = 0; k < PW; k++) begin
        acc_fa       = fa(sum_nxt[k], csh_v[k], pp_v[k]);
        sum_nxt[k]   = acc_fa[0];
        carry_nxt[k] = acc_fa[1];
      end
    end
  end

  always_comb begin
    csh_m   = carry_r << 1;
    rc      = 1'b0;
    merge_v = '0;
    mrg_fa  = '0;
    for (int k = 0; k < PW; k++) begin
      mrg_fa     = fa(sum_r[k], csh_m[k], rc);
      merge_v[k] = mrg_fa[0];
      rc         = mrg_fa[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // BUSY hands off once the counter shows every row has been folded in
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (row_cnt == ROWS_ALL) state_nxt = MERGE;
      MERGE:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      sum_r    <= '0;
      carry_r  <= '0;
      row_cnt  <= '0;
      product  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= b;
          signed_r <= (SIGNED_EN != 0) && is_signed;
          sum_r    <= '0;
          carry_r  <= '0;
          row_cnt  <= '0;
        end
        BUSY: if (row_cnt != ROWS_ALL) begin
          sum_r   <= sum_nxt;
          carry_r <= carry_nxt;
          row_cnt <= row_cnt + ROW_STEP;
        end
        MERGE:   product <= merge_v;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_csa_multiplier.sv
// Self-checking bench: an 8-bit/1-row instance for directed scenarios and a
// 16-bit/4-row instance for randomized operations against an arithmetic model.
module tb_seq_csa_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        v16, r16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_fail   = 0;

  seq_csa_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(1), .SIGNED_EN(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  seq_csa_multiplier #(.WIDTH(16), .ROWS_PER_CYCLE(4), .SIGNED_EN(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [31:0] ea, eb;
    ea = s ? {{16{a[15]}}, a} : {16'b0, a};
    eb = s ? {{16{b[15]}}, b} : {16'b0, b};
    return ea * eb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait (bounded) for out_valid; drains only if out_ready is high
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int lat);
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    p = p8;
    if (or8) tick();
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      output logic [31:0] p, output int lat);
    a16 = a; b16 = b; s16 = s; v16 = 1'b1;
    tick();
    v16 = 1'b0;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    p = p16;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (r8 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready8: got %b want 1", r8); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid8: got %b want 0", ov8); end
    n_checks++; if (p8 !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_product8: got %h want 0", p8); end
    n_checks++; if (r16 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready16: got %b want 1", r16); end
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid16: got %b want 0", ov16); end
    n_checks++; if (p16 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_product16: got %h want 0", p16); end
  endtask

  task automatic test_unsigned();
    logic [15:0] p;
    int lat;
    op8(8'hFF, 8'hFF, 1'b0, p, lat);
    n_checks++; if (p !== 16'hFE01) begin n_fail++; $display("[TB] FAIL t1_product: got %h want fe01", p); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("[TB] FAIL t1_latency: got %0d want 10", lat); end
    n_checks++; if (r8 !== 1'b1 || ov8 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL t1_idle_after: in_ready %b out_valid %b want 1 0", r8, ov8);
    end
  endtask

  task automatic test_signed();
    logic [7:0]  ta[4] = '{8'h80, 8'hFF, 8'h80, 8'h80};
    logic [7:0]  tb[4] = '{8'h80, 8'h01, 8'h7F, 8'h7F};
    logic        ts[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] te[4] = '{16'h4000, 16'hFFFF, 16'hC080, 16'h3F80};
    logic [15:0] p, e;
    logic [7:0]  ra, rb;
    logic        rs;
    int lat;
    for (int i = 0; i < 4; i++) begin
      op8(ta[i], tb[i], ts[i], p, lat);
      n_checks++; if (p !== te[i]) begin
        n_fail++; $display("[TB] FAIL sign_table%0d: %h*%h s=%b got %h want %h", i, ta[i], tb[i], ts[i], p, te[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      e = model8(ra, rb, rs);
      op8(ra, rb, rs, p, lat);
      n_checks++; if (p !== e || lat !== 10) begin
        n_fail++; $display("[TB] FAIL rand8: %h*%h s=%b got %h lat %0d want %h lat 10", ra, rb, rs, p, lat, e);
      end
    end
  endtask

  task automatic test_zero();
    logic [15:0] p;
    int lat;
    op8(8'h00, 8'hA5, 1'b1, p, lat);
    n_checks++; if (p !== 16'h0 || lat !== 10) begin
      n_fail++; $display("[TB] FAIL zero_a: got %h lat %0d want 0 lat 10", p, lat);
    end
    op8(8'h5A, 8'h00, 1'b0, p, lat);
    n_checks++; if (p !== 16'h0 || lat !== 10) begin
      n_fail++; $display("[TB] FAIL zero_b: got %h lat %0d want 0 lat 10", p, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    int lat;
    or8 = 1'b0;
    op8(8'h12, 8'h34, 1'b0, p, lat);
    n_checks++; if (p !== 16'h03A8) begin n_fail++; $display("[TB] FAIL bp_product: got %h want 03a8", p); end
    a8 = 8'h77; b8 = 8'h66; v8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (ov8 !== 1'b1 || r8 !== 1'b0 || p8 !== 16'h03A8) begin
        n_fail++; $display("[TB] FAIL bp_hold%0d: out_valid %b in_ready %b product %h want 1 0 03a8", i, ov8, r8, p8);
      end
    end
    v8 = 1'b0;
    or8 = 1'b1;
    tick();
    n_checks++; if (r8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h03A8) begin
      n_fail++; $display("[TB] FAIL bp_release: in_ready %b out_valid %b product %h want 1 0 03a8", r8, ov8, p8);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] p;
    int lat;
    a8 = 8'hC8; b8 = 8'h64; s8 = 1'b0; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (r8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h0) begin
      n_fail++; $display("[TB] FAIL rst_busy: in_ready %b out_valid %b product %h want 1 0 0", r8, ov8, p8);
    end
    op8(8'd3, 8'd5, 1'b0, p, lat);
    n_checks++; if (p !== 16'd15 || lat !== 10) begin
      n_fail++; $display("[TB] FAIL rst_next_op: got %0d lat %0d want 15 lat 10", p, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a8 = 8'd7; b8 = 8'd9; s8 = 1'b0; v8 = 1'b1; or8 = 1'b1;
    tick();
    a8 = 8'd11; b8 = 8'd13;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_checks++; if (p8 !== 16'd63 || lat !== 10) begin
      n_fail++; $display("[TB] FAIL b2b_first: got %0d lat %0d want 63 lat 10", p8, lat);
    end
    tick();
    n_checks++; if (r8 !== 1'b1 || ov8 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_idle: in_ready %b out_valid %b want 1 0", r8, ov8);
    end
    tick();
    v8 = 1'b0;
    n_checks++; if (r8 !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept: in_ready %b want 0", r8); end
    lat = 0;
    while (ov8 !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_checks++; if (p8 !== 16'd143 || lat !== 10) begin
      n_fail++; $display("[TB] FAIL b2b_second: got %0d lat %0d want 143 lat 10", p8, lat);
    end
    tick();
  endtask

  task automatic test_random16();
    logic [31:0] p, e;
    logic [15:0] ra, rb;
    logic        rs;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
      if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b0; end
      e = model16(ra, rb, rs);
      op16(ra, rb, rs, p, lat);
      n_checks++; if (p !== e) begin
        n_fail++; $display("[TB] FAIL rand16_product: %h*%h s=%b got %h want %h", ra, rb, rs, p, e);
      end
      n_checks++; if (lat !== 6) begin
        n_fail++; $display("[TB] FAIL rand16_latency: got %0d want 6", lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    v8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    v16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
